lcd_stream_sequencer: RTL and testbench

- Owns the single byte-wide output path into the LCD transmit FIFO and decides which source drives it.
- Sources: the init-sequence decoder, a pixel source, and an on-the-fly configuration requester.
- Sequences init → repeated frames (RAMWR command followed by the pixel payload).
- Config requests are serviced only at frame boundaries, so a frame is never interrupted.

---
 rtl/lcd_stream_sequencer_pkg.sv | 21 ++
 rtl/lcd_stream_sequencer_counter.sv | 39 +++
 rtl/lcd_stream_sequencer.sv | 178 +++++++++++++++++
 tb/tb_lcd_stream_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_stream_sequencer_pkg.sv
// Shared LCD controller definitions for the stream sequencer.
//   LCD_DISP_WIDTH / LCD_DISP_HEIGHT : panel geometry in pixels
//   LCD_BYTES_PER_PIXEL              : RGB565 pixel size
//   LCD_RAMWR_CMD                    : memory-write opcode opening every frame
//   state_t                          : sequencer states
package lcd_stream_sequencer_pkg;

   localparam int unsigned LCD_DISP_WIDTH      = 240;
   localparam int unsigned LCD_DISP_HEIGHT     = 280;
   localparam int unsigned LCD_BYTES_PER_PIXEL = 2;
   localparam logic [7:0]  LCD_RAMWR_CMD       = 8'h2C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_FRAME_CMD,
      ST_PIXELS,
      ST_CFG
   } state_t;

endpackage

// File: rtl/lcd_stream_sequencer_counter.sv
// Loadable byte down-counter for the pixel payload.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset (count -> 0)
//   load_i     : load TOTAL_BYTES-1
//   dec_i      : decrement by one (saturates at zero)
//   is_zero_o  : count is zero
module lcd_byte_counter #(
   parameter int unsigned  TOTAL_BYTES = 134400,
   localparam int unsigned CW = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic dec_i,
   output logic is_zero_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(TOTAL_BYTES - 1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_stream_sequencer.sv
// Owns the byte path into the LCD transmit FIFO and picks its source:
// init decoder, then back-to-back frames (RAMWR + pixel payload), with config
// bursts slotted in only at frame boundaries.
//   clk, rst (async active-low)
//   start / run                  : init kick pulse / frame streaming level
//   dec_*                        : init-sequence decoder source
//   px_*                         : pixel source
//   cfg_*                        : on-the-fly config requester
//   out_*                        : FIFO side, valid/ready
//   init_done, frame_start, busy : status
module lcd_stream_sequencer
   import lcd_stream_sequencer_pkg::*;
#(
   parameter int unsigned           WORD_WIDTH      = 8,
   parameter int unsigned           DISP_WIDTH      = LCD_DISP_WIDTH,
   parameter int unsigned           DISP_HEIGHT     = LCD_DISP_HEIGHT,
   parameter int unsigned           BYTES_PER_PIXEL = LCD_BYTES_PER_PIXEL,
   parameter logic [WORD_WIDTH-1:0] RAMWR_CMD       = WORD_WIDTH'(LCD_RAMWR_CMD)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  run,
   output logic                  dec_en,
   input  logic                  dec_valid,
   output logic                  dec_ready,
   input  logic [WORD_WIDTH-1:0] dec_data,
   input  logic                  dec_is_cmd,
   input  logic                  dec_done,
   input  logic                  px_valid,
   output logic                  px_ready,
   input  logic [WORD_WIDTH-1:0] px_data,
   input  logic                  cfg_req,
   output logic                  cfg_gnt,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [WORD_WIDTH-1:0] cfg_data,
   input  logic                  cfg_is_cmd,
   input  logic                  cfg_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_is_cmd,
   output logic                  init_done,
   output logic                  frame_start,
   output logic                  busy
);

   localparam int unsigned FRAME_BYTES = DISP_WIDTH * DISP_HEIGHT * BYTES_PER_PIXEL;

   state_t state_q, state_d;
   logic   init_done_q, init_done_d;
   // Set after a config burst, cleared at the next RAMWR. Lets IDLE start a
   // frame before granting a held cfg_req again, so a continuous requester
   // gets one burst per frame boundary instead of starving frames.
   logic   cfg_served_q, cfg_served_d;
   logic   hs;
   logic   cnt_load, cnt_dec, cnt_zero;

   // Output mux: purely from state so a source's byte reaches the FIFO in the
   // same cycle it is presented.
   always_comb begin
      out_valid  = 1'b0;
      out_data   = '0;
      out_is_cmd = 1'b0;
      dec_ready  = 1'b0;
      px_ready   = 1'b0;
      cfg_ready  = 1'b0;
      cfg_gnt    = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            out_valid  = dec_valid;
            out_data   = dec_data;
            out_is_cmd = dec_is_cmd;
            dec_ready  = out_ready;
         end
         ST_FRAME_CMD: begin
            out_valid  = 1'b1;
            out_data   = RAMWR_CMD;
            out_is_cmd = 1'b1;
         end
         ST_PIXELS: begin
            out_valid  = px_valid;
            out_data   = px_data;
            px_ready   = out_ready;
         end
         ST_CFG: begin
            cfg_gnt    = 1'b1;
            out_valid  = cfg_valid;
            out_data   = cfg_data;
            out_is_cmd = cfg_is_cmd;
            cfg_ready  = out_ready;
         end
         default: ;
      endcase
   end

   assign hs = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      init_done_d  = init_done_q;
      cfg_served_d = cfg_served_q;
      dec_en       = 1'b0;
      frame_start  = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !init_done_q) begin
               state_d = ST_INIT;
               dec_en  = rst;   // keep the kick quiet while reset is held
            end else if (init_done_q && cfg_req && !(cfg_served_q && run)) begin
               state_d = ST_CFG;
            end else if (init_done_q && run) begin
               state_d = ST_FRAME_CMD;
            end
         end
         ST_INIT: begin
            if (dec_done) begin
               init_done_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_FRAME_CMD: begin
            if (hs) begin
               frame_start  = 1'b1;
               cnt_load     = 1'b1;
               cfg_served_d = 1'b0;
               state_d      = ST_PIXELS;
            end
         end
         ST_PIXELS: begin
            if (hs) begin
               cnt_dec = 1'b1;
               if (cnt_zero) begin
                  if (cfg_req)  state_d = ST_CFG;
                  else if (run) state_d = ST_FRAME_CMD;
                  else          state_d = ST_IDLE;
               end
            end
         end
         ST_CFG: begin
            if (hs && cfg_last) begin
               cfg_served_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         init_done_q  <= 1'b0;
         cfg_served_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_done_q  <= init_done_d;
         cfg_served_q <= cfg_served_d;
      end
   end

   lcd_byte_counter #(
      .TOTAL_BYTES (FRAME_BYTES)
   ) u_byte_counter (
      .clk_i     (clk),
      .rst_ni    (rst),
      .load_i    (cnt_load),
      .dec_i     (cnt_dec),
      .is_zero_o (cnt_zero)
   );

   assign init_done = init_done_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_stream_sequencer.sv
module tb_lcd_stream_sequencer;

   // Small panel so whole frames fit in a short run: 10 x 6 x 2 = 120 bytes.
   localparam int unsigned TW = 10, TH = 6, TBPP = 2;
   localparam int          N  = TW * TH * TBPP;
   localparam logic [7:0]  RAMWR = 8'h2C;

   logic       clk, rst, start, run, dec_en, dec_valid, dec_ready, dec_is_cmd, dec_done;
   logic       px_valid, px_ready, cfg_req, cfg_gnt, cfg_valid, cfg_ready, cfg_is_cmd, cfg_last;
   logic       out_valid, out_ready, out_is_cmd, init_done, frame_start, busy;
   logic [7:0] dec_data, px_data, cfg_data, out_data;

   lcd_stream_sequencer #(
      .WORD_WIDTH (8), .DISP_WIDTH (TW), .DISP_HEIGHT (TH),
      .BYTES_PER_PIXEL (TBPP), .RAMWR_CMD (RAMWR)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .run (run),
      .dec_en (dec_en), .dec_valid (dec_valid), .dec_ready (dec_ready),
      .dec_data (dec_data), .dec_is_cmd (dec_is_cmd), .dec_done (dec_done),
      .px_valid (px_valid), .px_ready (px_ready), .px_data (px_data),
      .cfg_req (cfg_req), .cfg_gnt (cfg_gnt), .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready), .cfg_data (cfg_data), .cfg_is_cmd (cfg_is_cmd),
      .cfg_last (cfg_last), .out_valid (out_valid), .out_ready (out_ready),
      .out_data (out_data), .out_is_cmd (out_is_cmd), .init_done (init_done),
      .frame_start (frame_start), .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: expected FIFO stream as {is_cmd, data}.
   logic [8:0] obs[$], expq[$];
   logic [8:0] dec_q[$];
   logic [9:0] cfg_q[$];          // {last, is_cmd, data}
   logic [7:0] px_mem[4096];
   int mpx, px_idx;

   function automatic void push_frame(int npx);
      expq.push_back({1'b1, RAMWR});
      for (int i = 0; i < npx; i++) begin
         expq.push_back({1'b0, px_mem[mpx]});
         mpx++;
      end
   endfunction

   int run_drop_at, cfg_raise_at, ready_mode, dec_en_cnt, fs_cnt, first_gnt_len;
   bit cfg_en, px_rand, dec_active, hold_pend;
   logic [8:0] hold_val;

   task automatic advance(bit dec_hs, bit px_hs, bit cfg_hs, bit en_seen);
      start    = 1'b0;
      dec_done = 1'b0;
      if (en_seen) dec_active = 1'b1;
      if (dec_hs) begin
         void'(dec_q.pop_front());
         if (dec_q.size() == 0) begin
            dec_done   = 1'b1;
            dec_active = 1'b0;
         end
      end
      dec_valid = dec_active && (dec_q.size() > 0);
      if (dec_valid) {dec_is_cmd, dec_data} = dec_q[0];
      if (px_hs) px_idx++;
      px_data = px_mem[px_idx];
      if (!(px_valid && !px_hs)) px_valid = px_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cfg_hs) void'(cfg_q.pop_front());
      cfg_valid = (cfg_q.size() > 0);
      if (cfg_valid) {cfg_last, cfg_is_cmd, cfg_data} = cfg_q[0];
      if (cfg_raise_at >= 0 && obs.size() >= cfg_raise_at) cfg_en = 1'b1;
      cfg_req = cfg_en && (cfg_q.size() > 0);
      if (run_drop_at >= 0 && obs.size() >= run_drop_at) run = 1'b0;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = !out_ready;
         default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
   endtask

   task automatic cycle();
      bit hs, px_hs, dec_hs, cfg_hs, en_seen;
      @(negedge clk);
      if (hold_pend) begin
         check("hold_valid", out_valid, 1'b1);
         check("hold_data", {out_is_cmd, out_data}, hold_val);
      end
      if (dec_ready | px_ready | cfg_ready) begin
         check("ready_onehot", $onehot({dec_ready, px_ready, cfg_ready}), 1'b1);
         check("ready_mirror", out_ready, 1'b1);
      end
      if (frame_start) begin
         fs_cnt++;
         check("frame_start_on_ramwr", {out_valid, out_ready, out_is_cmd, out_data}, {3'b111, RAMWR});
      end
      if (cfg_gnt && first_gnt_len < 0) first_gnt_len = obs.size();
      hs = out_valid && out_ready;
      if (hs) obs.push_back({out_is_cmd, out_data});
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_is_cmd, out_data};
      px_hs  = px_valid && px_ready;
      dec_hs = dec_valid && dec_ready;
      cfg_hs = cfg_valid && cfg_ready;
      en_seen = dec_en;
      if (dec_en) dec_en_cnt++;
      @(posedge clk);
      #1;
      advance(dec_hs, px_hs, cfg_hs, en_seen);
   endtask

   task automatic wait_len(int target, int budget, string name);
      int c = 0;
      while (obs.size() < target && c < budget) begin
         cycle();
         c++;
      end
      check({name, "_progress"}, obs.size() >= target, 1'b1);
   endtask

   task automatic compare(string name);
      check({name, "_len"}, obs.size(), expq.size());
      for (int i = 0; i < obs.size() && i < expq.size(); i++)
         check($sformatf("%s_byte%0d", name, i), obs[i], expq[i]);
      obs.delete();
      expq.delete();
   endtask

   // Single-state vectors: inputs applied after an edge, outputs checked
   // before the next one. Expected flags {dec_en,busy,valid,is_cmd},
   // readys {dec,px,cfg,gnt}.
   typedef struct {
      logic st, rn, cr, dv, dc, pv, cv, ordy;
      logic [7:0] dd;
      logic [3:0] e_flags;
      logic [7:0] e_data;
      logic [3:0] e_rdy;
   } vec_t;

   function automatic vec_t mk(logic st, logic rn, logic cr, logic dv, logic dc, logic [7:0] dd,
                               logic pv, logic cv, logic ordy, logic [3:0] ef, logic [7:0] ed,
                               logic [3:0] er);
      vec_t v;
      v.st = st; v.rn = rn; v.cr = cr; v.dv = dv; v.dc = dc; v.dd = dd;
      v.pv = pv; v.cv = cv; v.ordy = ordy; v.e_flags = ef; v.e_data = ed; v.e_rdy = er;
      return v;
   endfunction

   vec_t tv[11];

   task automatic apply_vec(int i);
      @(posedge clk);
      #1;
      start = tv[i].st; run = tv[i].rn; cfg_req = tv[i].cr; dec_valid = tv[i].dv;
      dec_is_cmd = tv[i].dc; dec_data = tv[i].dd; px_valid = tv[i].pv;
      cfg_valid = tv[i].cv; out_ready = tv[i].ordy; dec_done = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {dec_en, busy, out_valid, out_is_cmd, out_data, dec_ready, px_ready, cfg_ready, cfg_gnt},
            {tv[i].e_flags, tv[i].e_data, tv[i].e_rdy});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [8:0] ini[4];
      logic [8:0] ini2[2];
      int c;
      ini  = '{9'h111, 9'h13A, 9'h055, 9'h129};
      ini2 = '{9'h101, 9'h0AA};
      for (int i = 0; i < 4096; i++) px_mem[i] = 8'($urandom);
      tv[0]  = mk(0,1,1,0,0,8'h00,1,1,1, 4'b0000, 8'h00, 4'b0000);
      tv[1]  = mk(1,0,0,0,0,8'h00,0,0,1, 4'b1000, 8'h00, 4'b0000);
      tv[2]  = mk(0,1,1,1,1,8'hA5,1,1,0, 4'b0111, 8'hA5, 4'b0000);
      tv[3]  = mk(0,0,0,1,0,8'h3C,0,0,1, 4'b0110, 8'h3C, 4'b1000);
      tv[4]  = mk(0,0,0,0,0,8'h00,0,0,1, 4'b0100, 8'h00, 4'b1000);
      tv[5]  = mk(1,0,0,1,1,8'hFF,0,0,0, 4'b0111, 8'hFF, 4'b0000);
      tv[6]  = mk(1,0,0,0,0,8'h00,0,0,1, 4'b0000, 8'h00, 4'b0000);
      tv[7]  = mk(0,0,0,0,0,8'h00,0,0,1, 4'b0000, 8'h00, 4'b0000);
      tv[8]  = mk(0,1,0,0,0,8'h00,1,0,0, 4'b0000, 8'h00, 4'b0000);
      tv[9]  = mk(0,1,0,0,0,8'h00,1,0,0, 4'b0111, 8'h2C, 4'b0000);
      tv[10] = mk(0,0,1,0,0,8'h00,0,1,0, 4'b0111, 8'h2C, 4'b0000);

      rst = 1'b0; start = 1'b0; run = 1'b0; dec_valid = 1'b0; dec_data = '0; dec_is_cmd = 1'b0;
      dec_done = 1'b0; px_valid = 1'b0; px_data = '0; cfg_req = 1'b0; cfg_valid = 1'b0;
      cfg_data = '0; cfg_is_cmd = 1'b0; cfg_last = 1'b0; out_ready = 1'b0;
      run_drop_at = -1; cfg_raise_at = -1; ready_mode = 0; cfg_en = 0; px_rand = 0;
      dec_active = 0; hold_pend = 0; first_gnt_len = -1; dec_en_cnt = 0; fs_cnt = 0;
      mpx = 0; px_idx = 0;

      // Reset with every input asserted: all outputs must stay low.
      repeat (2) @(posedge clk);
      #1;
      start = 1; run = 1; cfg_req = 1; dec_valid = 1; px_valid = 1; cfg_valid = 1; out_ready = 1;
      #1;
      check("rst_out", {out_valid, out_is_cmd, out_data}, 10'h0);
      check("rst_readys", {dec_ready, px_ready, cfg_ready, cfg_gnt}, 4'h0);
      check("rst_status", {dec_en, init_done, frame_start, busy}, 4'h0);
      start = 0; run = 0; cfg_req = 0; dec_valid = 0; px_valid = 0; cfg_valid = 0; out_ready = 0;
      @(posedge clk);
      #1 rst = 1'b1;

      // Table: uninitialised IDLE, start, INIT routing.
      for (int i = 0; i <= 5; i++) apply_vec(i);
      @(posedge clk);
      #1;
      {start, run, cfg_req, dec_valid, px_valid, cfg_valid, out_ready} = '0;
      dec_done = 1'b1;
      @(posedge clk);
      #1 dec_done = 1'b0;
      @(negedge clk);
      check("init_done_after_dec_done", {init_done, busy}, 2'b10);
      // Table: initialised IDLE ignores start, enters FRAME_CMD on run.
      for (int i = 6; i <= 10; i++) apply_vec(i);

      // Async reset out of FRAME_CMD.
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("rst_from_frame_cmd", {out_valid, busy, init_done}, 3'b000);
      {start, run, cfg_req, dec_valid, px_valid, cfg_valid, out_ready} = '0;
      @(posedge clk);
      #1 rst = 1'b1;

      // S1: init, two frames, cfg raised mid-frame 2, frame 3, run dropped.
      foreach (ini[i]) begin dec_q.push_back(ini[i]); expq.push_back(ini[i]); end
      push_frame(N);
      push_frame(N);
      cfg_q.push_back(10'h136); cfg_q.push_back(10'h000); cfg_q.push_back(10'h260);
      expq.push_back(9'h136); expq.push_back(9'h000); expq.push_back(9'h060);
      push_frame(N);
      run = 1; px_rand = 1; ready_mode = 2;
      cfg_raise_at = 4 + (N + 1) + 1 + 10;
      run_drop_at  = 4 + 2 * (N + 1) + 3 + 1 + 10;
      advance(0, 0, 0, 0);
      start = 1'b1;
      wait_len(expq.size(), 4000, "s1");
      repeat (20) cycle();
      check("s1_dec_en_pulses", dec_en_cnt, 1);
      check("s1_cfg_gnt_at_boundary", first_gnt_len, 4 + 2 * (N + 1));
      check("s1_frame_starts", fs_cnt, 3);
      check("s1_idle_after_run_drop", {busy, init_done}, 2'b01);
      compare("s1");

      // S2: cfg_req held across two bursts with out_ready toggling each cycle.
      cfg_q.push_back(10'h13A); cfg_q.push_back(10'h255);
      cfg_q.push_back(10'h12A); cfg_q.push_back(10'h000); cfg_q.push_back(10'h2EF);
      expq.push_back(9'h13A); expq.push_back(9'h055);
      push_frame(N);
      expq.push_back(9'h12A); expq.push_back(9'h000); expq.push_back(9'h0EF);
      push_frame(N);
      cfg_raise_at = -1; cfg_en = 1; run = 1; px_rand = 0; ready_mode = 1; fs_cnt = 0;
      run_drop_at = 2 + (N + 1) + 3 + 1 + 10;
      advance(0, 0, 0, 0);
      wait_len(expq.size(), 4000, "s2");
      repeat (20) cycle();
      check("s2_frame_starts", fs_cnt, 2);
      check("s2_idle", busy, 1'b0);
      compare("s2");

      // S3: async reset 30 bytes into PIXELS, then init re-runs.
      push_frame(30);
      cfg_en = 0; run = 1; px_rand = 1; ready_mode = 2; run_drop_at = -1;
      advance(0, 0, 0, 0);
      c = 0;
      while (obs.size() < 31 && c < 2000) begin cycle(); c++; end
      check("s3_progress", obs.size() >= 31, 1'b1);
      rst = 1'b0;
      #1;
      check("s3_rst_now", {out_valid, init_done, busy, frame_start, px_ready}, 5'b0);
      hold_pend = 0;
      compare("s3a");
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) cycle();
      check("s3_idle_uninit", {busy, init_done}, 2'b00);
      foreach (ini2[i]) begin dec_q.push_back(ini2[i]); expq.push_back(ini2[i]); end
      push_frame(N);
      dec_en_cnt = 0;
      run_drop_at = 2 + 1 + 5;
      start = 1'b1;
      wait_len(expq.size(), 2000, "s3");
      repeat (20) cycle();
      check("s3_dec_en_pulses", dec_en_cnt, 1);
      check("s3_reinit", {busy, init_done}, 2'b01);
      compare("s3b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
